// File: rtl/shift_latch_chain.sv
// shift_latch_chain: 595-style serial-in/parallel-out shift register with a separate output latch.
// Button-level strobes are synchronised, debounced and edge-detected on the system clock.
module shift_latch_chain #(
    parameter int unsigned       WIDTH      = 8,
    parameter logic [19:0]       DEB_CYCLES = 20'd1000,
    parameter logic [WIDTH-1:0]  RESET_VAL  = '1,
    parameter bit                AUTO_LATCH = 1'b0,
    parameter bit                STROBE_NEG = 1'b1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         ser,
    input  logic                         sck,
    input  logic                         rck,
    input  logic                         mr_n,
    input  logic                         oe_n,
    input  logic                         dir,
    output logic [WIDTH-1:0]             data,
    output logic                         qs,
    output logic [$clog2(WIDTH+1)-1:0]   cnt,
    output logic                         full,
    output logic                         latched
);

    localparam int unsigned CW    = $clog2(WIDTH + 1);
    localparam int unsigned NIN   = 4;
    localparam int unsigned DW    = 20;
    localparam int unsigned I_SER = 0;
    localparam int unsigned I_SCK = 1;
    localparam int unsigned I_RCK = 2;
    localparam int unsigned I_MR  = 3;

    // Input conditioning state, one lane per button input
    logic [NIN-1:0] pin_c;
    logic [NIN-1:0] sync1;
    logic [NIN-1:0] sync2;
    logic [NIN-1:0] stable;
    logic [NIN-1:0] stable_n;
    logic [NIN-1:0] differ_c;
    logic [NIN-1:0] accept_c;
    logic [DW-1:0]  dcnt   [NIN];
    logic [DW-1:0]  dcnt_n [NIN];

    // Core state
    logic [WIDTH-1:0] sreg;
    logic [WIDTH-1:0] sreg_n;
    logic [WIDTH-1:0] lreg;
    logic [WIDTH-1:0] lreg_n;
    logic [WIDTH-1:0] shifted_c;
    logic [CW-1:0]    cnt_n;
    logic             pend;
    logic             pend_n;
    logic             edge_lvl_c;
    logic             shift_c;
    logic             rck_c;
    logic             clear_c;
    logic             latch_c;

    assign pin_c      = {mr_n, rck, sck, ser};
    assign edge_lvl_c = ~STROBE_NEG;

    // Debounce: stable level follows the synced level after it has differed long enough
    always_comb begin
        differ_c = '0;
        accept_c = '0;
        stable_n = stable;
        for (int i = 0; i < NIN; i++) begin
            dcnt_n[i]   = '0;
            differ_c[i] = (sync2[i] != stable[i]);
            accept_c[i] = differ_c[i] && (dcnt[i] >= DEB_CYCLES);
            if (accept_c[i]) begin
                stable_n[i] = sync2[i];
            end
            if (differ_c[i] && !accept_c[i]) begin
                dcnt_n[i] = dcnt[i] + DW'(1);
            end
        end
    end

    // Synchroniser, debounce counters and stable levels; idle level is 1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1  <= '1;
            sync2  <= '1;
            stable <= '1;
            for (int i = 0; i < NIN; i++) begin
                dcnt[i] <= '0;
            end
        end else begin
            sync1  <= pin_c;
            sync2  <= sync1;
            stable <= stable_n;
            for (int i = 0; i < NIN; i++) begin
                dcnt[i] <= dcnt_n[i];
            end
        end
    end

    // Strobe decode: a pulse is the accepted stable transition of the chosen polarity
    assign shift_c   = accept_c[I_SCK] && (sync2[I_SCK] == edge_lvl_c);
    assign rck_c     = accept_c[I_RCK] && (sync2[I_RCK] == edge_lvl_c);
    assign clear_c   = ~stable[I_MR];
    assign latch_c   = rck_c || (AUTO_LATCH && pend);
    assign shifted_c = dir ? {sreg[WIDTH-2:0], stable[I_SER]}
                           : {stable[I_SER], sreg[WIDTH-1:1]};

    // Next-state: latch takes the pre-update word; clear beats shift
    always_comb begin
        sreg_n = sreg;
        lreg_n = lreg;
        cnt_n  = cnt;
        pend_n = 1'b0;
        if (latch_c) begin
            lreg_n = sreg;
            cnt_n  = '0;
        end
        if (clear_c) begin
            sreg_n = RESET_VAL;
            cnt_n  = '0;
        end else if (shift_c) begin
            sreg_n = shifted_c;
            if (latch_c) begin
                cnt_n = CW'(1);
            end else if (cnt != CW'(WIDTH)) begin
                cnt_n = cnt + CW'(1);
            end
            pend_n = AUTO_LATCH && !latch_c && (cnt == CW'(WIDTH - 1));
        end
    end

    // Shift/latch registers and registered status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sreg    <= RESET_VAL;
            lreg    <= RESET_VAL;
            cnt     <= '0;
            full    <= 1'b0;
            pend    <= 1'b0;
            latched <= 1'b0;
        end else begin
            sreg    <= sreg_n;
            lreg    <= lreg_n;
            cnt     <= cnt_n;
            full    <= (cnt_n == CW'(WIDTH));
            pend    <= pend_n;
            latched <= latch_c;
        end
    end

    // Output enable blanks to the reset word; cascade bit follows shift direction
    assign data = oe_n ? RESET_VAL : lreg;
    assign qs   = dir ? sreg[WIDTH-1] : sreg[0];

endmodule

// File: tb/tb_shift_latch_chain.sv
// Bench for shift_latch_chain: directed button sequences, latched words checked through a scoreboard.
module tb_shift_latch_chain;

    localparam int unsigned W  = 8;
    localparam int unsigned CW = 4;

    logic clk = 1'b0;
    logic rst_n;

    logic ser, sck, rck, mr_n, oe_n, dir;
    logic [W-1:0]  data;
    logic          qs, full, latched;
    logic [CW-1:0] cnt;

    logic a_ser, a_sck, a_rck, a_mr_n, a_oe_n, a_dir;
    logic [W-1:0]  a_data;
    logic          a_qs, a_full, a_latched;
    logic [CW-1:0] a_cnt;

    int checks   = 0;
    int failures = 0;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp_a_q[$];
    logic prev_l  = 1'b0;
    logic prev_la = 1'b0;

    always #5 clk = ~clk;

    shift_latch_chain #(
        .WIDTH(W), .DEB_CYCLES(20'd4), .RESET_VAL(8'hFF), .AUTO_LATCH(1'b0), .STROBE_NEG(1'b1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ser(ser), .sck(sck), .rck(rck), .mr_n(mr_n), .oe_n(oe_n),
        .dir(dir), .data(data), .qs(qs), .cnt(cnt), .full(full), .latched(latched)
    );

    shift_latch_chain #(
        .WIDTH(W), .DEB_CYCLES(20'd4), .RESET_VAL(8'hFF), .AUTO_LATCH(1'b1), .STROBE_NEG(1'b1)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .ser(a_ser), .sck(a_sck), .rck(a_rck), .mr_n(a_mr_n), .oe_n(a_oe_n),
        .dir(a_dir), .data(a_data), .qs(a_qs), .cnt(a_cnt), .full(a_full), .latched(a_latched)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_ser(input logic b);
        ser = b;
        tick(8);
    endtask

    // Hold the selected buttons long enough to be accepted, then release and settle
    task automatic press(input bit ps, input bit pr, input bit pm);
        if (ps) sck = 1'b0;
        if (pr) rck = 1'b0;
        if (pm) mr_n = 1'b0;
        tick(8);
        sck  = 1'b1;
        rck  = 1'b1;
        mr_n = 1'b1;
        tick(8);
    endtask

    task automatic shift_word(input logic [W-1:0] w);
        for (int i = 0; i < W; i++) begin
            set_ser(w[i]);
            press(1'b1, 1'b0, 1'b0);
        end
    endtask

    task automatic a_shift_bit(input logic b);
        a_ser = b;
        tick(8);
        a_sck = 1'b0;
        tick(8);
        a_sck = 1'b1;
        tick(8);
    endtask

    task automatic sample;
        @(negedge clk);
    endtask

    // Scoreboard monitor: every latch pulse must match the next queued word and last one cycle
    always @(negedge clk) begin
        if (rst_n) begin
            if (latched) begin
                chk("latched_pulse_width", 32'(prev_l), 32'd0);
                if (exp_q.size() == 0) chk("unexpected_latch", 32'd1, 32'd0);
                else chk("latched_data", 32'(data), 32'(exp_q.pop_front()));
            end
            if (a_latched) begin
                chk("a_latched_pulse_width", 32'(prev_la), 32'd0);
                if (exp_a_q.size() == 0) chk("a_unexpected_latch", 32'd1, 32'd0);
                else chk("a_latched_data", 32'(a_data), 32'(exp_a_q.pop_front()));
            end
        end
        prev_l  = latched;
        prev_la = a_latched;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_n = 1'b0;
        ser = 1'b1; sck = 1'b1; rck = 1'b1; mr_n = 1'b1; oe_n = 1'b0; dir = 1'b0;
        a_ser = 1'b1; a_sck = 1'b1; a_rck = 1'b1; a_mr_n = 1'b1; a_oe_n = 1'b0; a_dir = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_data", 32'(data), 32'hFF);
        chk("reset_cnt", 32'(cnt), 32'd0);
        chk("reset_full", 32'(full), 32'd0);
        chk("reset_qs", 32'(qs), 32'd1);
        chk("reset_latched", 32'(latched), 32'd0);
        chk("a_reset_data", 32'(a_data), 32'hFF);
        tick(1);
        rst_n = 1'b1;
        tick(4);

        // Right shift of A5, LSB first, then manual latch
        shift_word(8'hA5);
        sample;
        chk("a5_cnt_full", 32'(cnt), 32'd8);
        chk("a5_full", 32'(full), 32'd1);
        chk("a5_qs_dir0", 32'(qs), 32'd1);
        chk("a5_data_prelatch", 32'(data), 32'hFF);
        exp_q.push_back(8'hA5);
        press(1'b0, 1'b1, 1'b0);
        sample;
        chk("a5_data", 32'(data), 32'hA5);
        chk("a5_cnt_after_latch", 32'(cnt), 32'd0);
        chk("a5_full_after_latch", 32'(full), 32'd0);

        // Left shift of 1,0,0,0,0,0,0,0
        dir = 1'b1;
        #1;
        chk("a5_qs_dir1", 32'(qs), 32'd1);
        shift_word(8'h01);
        sample;
        chk("h80_cnt", 32'(cnt), 32'd8);
        exp_q.push_back(8'h80);
        press(1'b0, 1'b1, 1'b0);
        sample;
        chk("h80_data", 32'(data), 32'h80);
        chk("h80_cnt_after_latch", 32'(cnt), 32'd0);
        chk("h80_qs_dir1", 32'(qs), 32'd1);
        dir = 1'b0;
        #1;
        chk("h80_qs_dir0", 32'(qs), 32'd0);
        dir = 1'b1;

        // Nine shifts saturate the counter
        set_ser(1'b0);
        repeat (9) press(1'b1, 1'b0, 1'b0);
        sample;
        chk("sat_cnt", 32'(cnt), 32'd8);
        chk("sat_full", 32'(full), 32'd1);
        chk("sat_qs", 32'(qs), 32'd0);
        exp_q.push_back(8'h00);
        press(1'b0, 1'b1, 1'b0);
        sample;
        chk("sat_data", 32'(data), 32'h00);

        // Bouncing strobe is ignored; a clean 6-cycle press shifts once
        dir = 1'b0;
        set_ser(1'b1);
        for (int k = 0; k < 5; k++) begin
            sck = 1'b0;
            tick(3);
            sck = 1'b1;
            tick(3);
        end
        tick(10);
        sample;
        chk("bounce_cnt", 32'(cnt), 32'd0);
        sck = 1'b0;
        tick(6);
        sck = 1'b1;
        tick(10);
        sample;
        chk("clean_press_cnt", 32'(cnt), 32'd1);
        chk("clean_press_qs", 32'(qs), 32'd0);

        // Clear together with a shift: clear wins, latch untouched
        press(1'b1, 1'b0, 1'b1);
        sample;
        chk("clear_cnt", 32'(cnt), 32'd0);
        chk("clear_full", 32'(full), 32'd0);
        chk("clear_qs", 32'(qs), 32'd1);
        chk("clear_data_kept", 32'(data), 32'h00);
        exp_q.push_back(8'hFF);
        press(1'b0, 1'b1, 1'b0);
        sample;
        chk("clear_latched_data", 32'(data), 32'hFF);

        // Latch together with a shift: pre-shift word latched, count restarts at 1
        set_ser(1'b0);
        press(1'b1, 1'b0, 1'b0);
        exp_q.push_back(8'h7F);
        press(1'b1, 1'b1, 1'b0);
        sample;
        chk("latch_shift_data", 32'(data), 32'h7F);
        chk("latch_shift_cnt", 32'(cnt), 32'd1);
        exp_q.push_back(8'h3F);
        press(1'b0, 1'b1, 1'b0);
        sample;
        chk("latch_shift_followup", 32'(data), 32'h3F);

        // Auto-latch instance: 3C shifted in, latched one cycle after the eighth shift
        for (int i = 0; i < 7; i++) a_shift_bit(1'((8'h3C >> i) & 8'h01));
        sample;
        chk("a_cnt_7", 32'(a_cnt), 32'd7);
        chk("a_data_pre", 32'(a_data), 32'hFF);
        exp_a_q.push_back(8'h3C);
        a_ser = 1'b0;
        tick(8);
        a_sck = 1'b0;
        n = 0;
        sample;
        while (a_cnt != CW'(8) && n < 20) begin
            sample;
            n++;
        end
        chk("a_cnt_reach8", 32'(a_cnt), 32'd8);
        chk("a_data_at_shift", 32'(a_data), 32'hFF);
        sample;
        chk("a_data_after", 32'(a_data), 32'h3C);
        chk("a_latched_after", 32'(a_latched), 32'd1);
        chk("a_cnt_after", 32'(a_cnt), 32'd0);
        a_sck = 1'b1;
        tick(8);
        a_oe_n = 1'b1;
        #1;
        chk("a_oe_off", 32'(a_data), 32'hFF);
        a_oe_n = 1'b0;
        #1;
        chk("a_oe_on", 32'(a_data), 32'h3C);

        tick(5);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        chk("a_scoreboard_drained", 32'(exp_a_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
